// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit and the controller
// decoder that drives it.
//   - op encodings MDU_NONE .. MDU_MSUBU (4-bit `op` field)
//   - FSM state type (S_IDLE, S_BUSY)
//   - default latencies for the mult and div families
package mdu_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MTHI  = 4'd5;
    localparam logic [3:0] MDU_MTLO  = 4'd6;
    localparam logic [3:0] MDU_MADD  = 4'd7;
    localparam logic [3:0] MDU_MADDU = 4'd8;
    localparam logic [3:0] MDU_MSUB  = 4'd9;
    localparam logic [3:0] MDU_MSUBU = 4'd10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } mdu_state_t;

    localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
    localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu.sv
// mdu: multi-cycle multiply/divide unit owning the HI/LO registers.
// The 64-bit result is computed when a request is accepted and held as a
// pending value; HI/LO are updated after MULT_CYCLES or DIV_CYCLES cycles,
// while `busy` is high. mthi/mtlo write HI/LO immediately.
// Optional macro MDU_MADD_EN enables madd/maddu/msub/msubu (ops 7..10);
// without it those ops are no-ops and no accumulator logic exists.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset, clears all state
//   start  in   one-cycle request, qualified by op
//   op     in   [3:0] operation code (see mdu_pkg)
//   A      in   [31:0] rs operand
//   B      in   [31:0] rt operand
//   busy   out  operation in flight
//   HI     out  [31:0] architectural HI
//   LO     out  [31:0] architectural LO
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES);
    localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES);

    mdu_state_t  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [63:0] pend_q, pend_d;

    logic [63:0] prod_s, prod_u;
    logic        div_signed;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;

    // Arithmetic. Signed division goes through magnitudes so that the
    // 0x80000000 / -1 overflow case wraps to 0x80000000 with remainder 0.
    always_comb begin
        prod_s     = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u     = {32'd0, A} * {32'd0, B};
        div_signed = (op == MDU_DIV);
        a_mag      = (div_signed && A[31]) ? (32'd0 - A) : A;
        b_mag      = (div_signed && B[31]) ? (32'd0 - B) : B;
        q_mag      = '0;
        r_mag      = '0;
        if (b_mag != 32'd0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        quo = (div_signed && (A[31] ^ B[31])) ? (32'd0 - q_mag) : q_mag;
        rem = (div_signed && A[31]) ? (32'd0 - r_mag) : r_mag;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        pend_d  = pend_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        MDU_MULT: begin
                            pend_d  = prod_s;
                            cnt_d   = MULT_LOAD;
                            state_d = S_BUSY;
                        end
                        MDU_MULTU: begin
                            pend_d  = prod_u;
                            cnt_d   = MULT_LOAD;
                            state_d = S_BUSY;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            // Divide by zero re-writes the current HI/LO.
                            pend_d  = (B == 32'd0) ? {hi_q, lo_q} : {rem, quo};
                            cnt_d   = DIV_LOAD;
                            state_d = S_BUSY;
                        end
                        MDU_MTHI: hi_d = A;
                        MDU_MTLO: lo_d = A;
`ifdef MDU_MADD_EN
                        MDU_MADD: begin
                            pend_d  = {hi_q, lo_q} + prod_s;
                            cnt_d   = MULT_LOAD;
                            state_d = S_BUSY;
                        end
                        MDU_MADDU: begin
                            pend_d  = {hi_q, lo_q} + prod_u;
                            cnt_d   = MULT_LOAD;
                            state_d = S_BUSY;
                        end
                        MDU_MSUB: begin
                            pend_d  = {hi_q, lo_q} - prod_s;
                            cnt_d   = MULT_LOAD;
                            state_d = S_BUSY;
                        end
                        MDU_MSUBU: begin
                            pend_d  = {hi_q, lo_q} - prod_u;
                            cnt_d   = MULT_LOAD;
                            state_d = S_BUSY;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                // Requests are ignored here; only the countdown advances.
                if (cnt_q == 5'd1) begin
                    hi_d    = pend_q[63:32];
                    lo_d    = pend_q[31:0];
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            pend_q  <= pend_d;
        end
    end

    assign busy = (state_q == S_BUSY);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: directed self-checking bench for mdu with default latencies.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] A, B;
    logic        busy;
    logic [31:0] HI, LO;

    int n_checks = 0;
    int n_pass   = 0;
    int n;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // One-cycle request; returns at the falling edge after the accepting edge.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0; op = MDU_NONE; A = '0; B = '0;
    endtask

    // Counts falling edges with busy high, bounded.
    task automatic wait_busy(output int cnt);
        cnt = 0;
        while (busy && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic run(input string tag, input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int exp_busy,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int c;
        issue(o, a, b);
        wait_busy(c);
        check({tag, "_busy"}, c, exp_busy);
        check({tag, "_hi"}, HI, exp_hi);
        check({tag, "_lo"}, LO, exp_lo);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = MDU_NONE; A = '0; B = '0;
        repeat (2) @(negedge clk);
        check("rst_hi", HI, 0);
        check("rst_lo", LO, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;

        // mthi then mtlo on consecutive cycles
        @(negedge clk);
        start = 1'b1; op = MDU_MTHI; A = 32'h12345678;
        @(negedge clk);
        check("mthi_hi", HI, 32'h12345678);
        check("mthi_lo", LO, 0);
        check("mthi_busy", busy, 0);
        op = MDU_MTLO; A = 32'h9ABCDEF0;
        @(negedge clk);
        start = 1'b0; op = MDU_NONE; A = '0;
        check("mtlo_hi", HI, 32'h12345678);
        check("mtlo_lo", LO, 32'h9ABCDEF0);
        check("mtlo_busy", busy, 0);

        run("mult",   MDU_MULT,  32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run("multu",  MDU_MULTU, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA);
        run("div",    MDU_DIV,   32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run("divu0",  MDU_DIVU,  32'd7, 32'd0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run("divovf", MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000);
        run("divu",   MDU_DIVU,  32'd100, 32'd7, 10, 32'd2, 32'd14);
        run("divneg", MDU_DIV,   32'd7, 32'hFFFFFFFE, 10, 32'd1, 32'hFFFFFFFD);

        // Requests during BUSY are ignored
        issue(MDU_MULT, 32'd6, 32'd7);
        check("stall_busy", busy, 1);
        start = 1'b1; op = MDU_MTLO; A = 32'hDEADBEEF;
        @(negedge clk);
        check("stall_lo_hold", LO, 32'hFFFFFFFD);
        op = MDU_DIV; A = 32'd100; B = 32'd7;
        @(negedge clk);
        start = 1'b0; op = MDU_NONE; A = '0; B = '0;
        wait_busy(n);
        check("stall_rest", n, 3);
        check("stall_hi", HI, 0);
        check("stall_lo", LO, 42);
        @(negedge clk);
        check("stall_nodiv", busy, 0);

        run("nop0",  MDU_NONE, 32'd5, 32'd5, 0, 32'd0, 32'd42);
        run("nop11", 4'd11,    32'd5, 32'd5, 0, 32'd0, 32'd42);

        issue(MDU_MTHI, 32'd0, 32'd0);
        issue(MDU_MTLO, 32'hFFFFFFFF, 32'd0);
`ifdef MDU_MADD_EN
        run("madd",  MDU_MADD,  32'd1, 32'd1, 5, 32'd1, 32'd0);
        run("msubu", MDU_MSUBU, 32'd2, 32'd1, 5, 32'd0, 32'hFFFFFFFE);
`else
        run("madd",  MDU_MADD,  32'd1, 32'd1, 0, 32'd0, 32'hFFFFFFFF);
        run("msubu", MDU_MSUBU, 32'd2, 32'd1, 0, 32'd0, 32'hFFFFFFFF);
`endif

        // Asynchronous reset mid-division
        issue(MDU_MTHI, 32'hA5A5A5A5, 32'd0);
        issue(MDU_DIV, 32'd100, 32'd7);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_hi", HI, 0);
        check("arst_lo", LO, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        check("arst_late_hi", HI, 0);
        check("arst_late_lo", LO, 0);
        check("arst_late_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
